controle_varredura: RTL and testbench
=====================================

Name: controle_varredura

Overview:
- Sequencer for the 4-bit code converter (A,B,C,D -> S3..S0) and its four 7-segment Display instances.
- Automatically sweeps input codes 0..15, or steps through them one at a time. For each code it:
  - drives the converter inputs and asserts its ready;
  - waits a settle time and captures S3..S0;
  - holds the captured value on the displays for a programmable time.
- Replaces hand-written stimulus loops; sits between the board controls and the converter/display datapath.

Parameters:
SETTLE_CYCLES, 2, cycles entrada is held stable with ready_cod=1 before capture (>=1)
HOLD_CYCLES, 4, cycles each captured code is shown with ready_disp=1 (>=1)
CNT_W, 4, width of the settle/hold counter; must hold max(SETTLE_CYCLES,HOLD_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level; sampled in IDLE to begin a sweep
step_mode  input  1  1 = wait for avanca after each SHOW; 0 = free-running
avanca  input  1  single-cycle pulse, advance to next code in step mode
abortar  input  1  synchronous abort, returns to IDLE next cycle
S  input  4  converter outputs {S3,S2,S1,S0}
entrada  output  4  converter inputs {A,B,C,D}, A = MSB
ready_cod  output  1  converter ready
reset_disp  output  1  display reset pulse
ready_disp  output  1  display ready
saida  output  4  captured code, drives Display entrada lines
cap_valid  output  1  one-cycle strobe when saida updated
soma  output  8  running sum of captured codes, mod 256
busy  output  1  1 in any state except IDLE/DONE
done  output  1  1 in DONE

Behaviour:
- Reset (async, immediate):
  - state=IDLE; idx=0; counter=0.
  - All outputs 0: entrada=0, saida=0, soma=0, ready_cod/ready_disp/reset_disp/cap_valid/busy/done=0.
- States: IDLE, CLR, APPLY, CAPTURE, SHOW, WAIT_STEP, DONE. All transitions on rising clk.
- IDLE:
  - start=1 -> CLR. The same edge clears idx and soma.
  - start=0 -> stay.
- CLR: exactly 1 cycle; reset_disp=1; -> APPLY with counter=0.
- APPLY:
  - entrada=idx; ready_cod=1; counter increments each cycle.
  - Lasts SETTLE_CYCLES cycles, then -> CAPTURE.
- CAPTURE:
  - 1 cycle; entrada=idx; ready_cod=1.
  - At its closing edge: saida<=S; soma<=soma+{4'b0,S}, wrapping mod 256; cap_valid=1 during the following cycle (first SHOW cycle).
- SHOW:
  - ready_disp=1; ready_cod=0; entrada keeps idx.
  - Lasts HOLD_CYCLES cycles. At the end:
    - step_mode=1 -> WAIT_STEP;
    - else idx==15 -> DONE;
    - else idx<=idx+1 and -> APPLY.
- WAIT_STEP:
  - ready_disp=1; stay until avanca=1.
  - Then idx==15 -> DONE, else idx+1 and -> APPLY.
  - avanca pulses outside WAIT_STEP are ignored, not queued.
- DONE:
  - done=1; saida and soma hold their values.
  - start=0 -> IDLE. start still 1 -> stay; a new sweep requires start to go low and then high again.
- Free-run latency: first CLR cycle to first DONE cycle = 1+16*(SETTLE_CYCLES+1+HOLD_CYCLES) cycles (113 with defaults).
- idx is 4 bits and never wraps past 15; termination is decided before the increment.
- abortar=1 in any non-IDLE state:
  - next state IDLE; ready_cod/ready_disp/reset_disp=0.
  - saida and soma hold; done=0.
  - abortar has priority over avanca, counter expiry and start.
- step_mode is sampled only at SHOW expiry; changing it mid-sweep affects the next code only.
- reset asserted mid-sweep overrides everything asynchronously; operation restarts only via IDLE+start.
- cap_valid is never high in two consecutive cycles.

Test Plan:
- Reset then idle: reset=1 at t=0, release; start=0 for 20 cycles -> all outputs 0, state IDLE, busy=0.
- Full free-run sweep: defaults, step_mode=0, pulse start, bench converter model maps 0->11, 1->9, 2->6, 3->15 ... 15->13.
  - Expected: reset_disp high exactly 1 cycle; entrada steps 0..15.
  - 16 cap_valid strobes with saida = 11, 9, 6, 15, 5, 2, 12, 14, 7, 0, 8, 10, 1, 3, 4, 13.
  - done rises exactly 113 cycles after CLR; soma=120.
- Step mode: step_mode=1, start; no avanca for 50 cycles -> entrada=0 and saida=11 stay; 3 avanca pulses -> entrada=3, saida=15. An avanca during APPLY is ignored (idx unchanged).
- Abort: abortar during SHOW of idx=5 -> next cycle IDLE, ready_cod/ready_disp=0, saida=2 held, soma=48. Restart via start -> soma cleared, sweep begins again at idx=0.
- Async reset mid-APPLY: reset pulsed between clock edges at idx=7 -> outputs 0 immediately, before the next edge.
- DONE re-arm: keep start=1 through DONE -> done stays 1 and no restart; drop start -> IDLE; raise start -> new sweep, soma=120 again.

Source files
------------

// File: rtl/controle_varredura.sv
// Sweep sequencer for the 4-bit code converter and its 7-segment displays:
// applies codes 0..15, captures S after a settle time, holds each result on the displays.
module controle_varredura #(
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step_mode,
  input  logic       avanca,
  input  logic       abortar,
  input  logic [3:0] S,
  output logic [3:0] entrada,
  output logic       ready_cod,
  output logic       reset_disp,
  output logic       ready_disp,
  output logic [3:0] saida,
  output logic       cap_valid,
  output logic [7:0] soma,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_APPLY,
    ST_CAPTURE,
    ST_SHOW,
    ST_WAIT_STEP,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       saida_q, saida_d;
  logic [7:0]       soma_q, soma_d;
  logic             cap_valid_q, cap_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      cnt_q       <= '0;
      saida_q     <= 4'd0;
      soma_q      <= 8'd0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      saida_q     <= saida_d;
      soma_q      <= soma_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    saida_d     = saida_q;
    soma_d      = soma_q;
    cap_valid_d = 1'b0;
    // abort outranks start, avanca and counter expiry; captured data is left untouched
    if (abortar) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_CLR;
            idx_d   = 4'd0;
            soma_d  = 8'd0;
            cnt_d   = '0;
          end
        end
        ST_CLR: begin
          state_d = ST_APPLY;
          cnt_d   = '0;
        end
        ST_APPLY: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_CAPTURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_CAPTURE: begin
          state_d     = ST_SHOW;
          cnt_d       = '0;
          saida_d     = S;
          soma_d      = soma_q + {4'b0000, S};
          cap_valid_d = 1'b1;
        end
        ST_SHOW: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            // termination is decided on the current index, before any increment
            if (step_mode) begin
              state_d = ST_WAIT_STEP;
            end else if (idx_q == 4'd15) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = ST_APPLY;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_STEP: begin
          if (avanca) begin
            cnt_d = '0;
            if (idx_q == 4'd15) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = ST_APPLY;
            end
          end
        end
        ST_DONE: begin
          if (!start) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    entrada    = 4'd0;
    ready_cod  = 1'b0;
    reset_disp = 1'b0;
    ready_disp = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_CLR:  reset_disp = 1'b1;
      ST_APPLY, ST_CAPTURE: begin
        entrada   = idx_q;
        ready_cod = 1'b1;
      end
      ST_SHOW, ST_WAIT_STEP: begin
        entrada    = idx_q;
        ready_disp = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign saida     = saida_q;
  assign soma      = soma_q;
  assign cap_valid = cap_valid_q;

endmodule

// File: tb/tb_controle_varredura.sv
// Directed bench for controle_varredura with a behavioural model of the code converter.
module tb_controle_varredura;

  logic       clk = 1'b0;
  logic       reset, start, step_mode, avanca, abortar;
  logic [3:0] S, entrada, saida;
  logic       ready_cod, reset_disp, ready_disp, cap_valid, busy, done;
  logic [7:0] soma;
  logic [21:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  controle_varredura dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
    .avanca(avanca), .abortar(abortar), .S(S), .entrada(entrada),
    .ready_cod(ready_cod), .reset_disp(reset_disp), .ready_disp(ready_disp),
    .saida(saida), .cap_valid(cap_valid), .soma(soma), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] conv(input logic [3:0] a);
    case (a)
      4'd0: return 4'd11;  4'd1: return 4'd9;   4'd2: return 4'd6;   4'd3: return 4'd15;
      4'd4: return 4'd5;   4'd5: return 4'd2;   4'd6: return 4'd12;  4'd7: return 4'd14;
      4'd8: return 4'd7;   4'd9: return 4'd0;   4'd10: return 4'd8;  4'd11: return 4'd10;
      4'd12: return 4'd1;  4'd13: return 4'd3;  4'd14: return 4'd4;  default: return 4'd13;
    endcase
  endfunction

  always_comb S = conv(entrada);
  assign outs = {entrada, ready_cod, reset_disp, ready_disp, saida, cap_valid, soma, busy, done};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; avanca = 1'b0; abortar = 1'b0;
    #1;
    n_checks++;
    if (outs !== 22'd0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", outs); end
    #12 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (outs !== 22'd0) begin n_fail++; $display("FAIL idle_outs cycle %0d: got %h expected 0", i, outs); end
    end
  endtask

  task automatic test_free_run;
    int cyc, k, nrd;
    logic prev_cv, fin;
    step_mode = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    n_checks++;
    if (reset_disp !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL clr_state: reset_disp=%b busy=%b expected 1 1", reset_disp, busy); end
    cyc = 0; k = 0; nrd = 1; prev_cv = 1'b0; fin = 1'b0;
    while (!fin && cyc < 300) begin
      tick(); cyc++;
      if (reset_disp) nrd++;
      if (ready_cod) begin
        n_checks++;
        if (entrada !== k[3:0]) begin n_fail++; $display("FAIL entrada_seq: got %0d expected %0d", entrada, k); end
      end
      if (cap_valid) begin
        n_checks++;
        if (saida !== conv(k[3:0]) || prev_cv) begin
          n_fail++; $display("FAIL capture %0d: saida=%0d prev_cv=%b expected saida=%0d prev_cv=0", k, saida, prev_cv, conv(k[3:0]));
        end
        k++;
      end
      prev_cv = cap_valid;
      if (done) fin = 1'b1;
    end
    n_checks++;
    if (!fin || cyc != 113) begin n_fail++; $display("FAIL done_latency: got %0d (fin=%b) expected 113", cyc, fin); end
    n_checks++;
    if (k != 16) begin n_fail++; $display("FAIL capture_count: got %0d expected 16", k); end
    n_checks++;
    if (nrd != 1) begin n_fail++; $display("FAIL reset_disp_cycles: got %0d expected 1", nrd); end
    n_checks++;
    if (soma !== 8'd120 || saida !== 4'd13) begin n_fail++; $display("FAIL final_sum: soma=%0d saida=%0d expected 120 13", soma, saida); end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || soma !== 8'd120) begin n_fail++; $display("FAIL back_to_idle: done=%b busy=%b soma=%0d expected 0 0 120", done, busy, soma); end
  endtask

  task automatic test_step;
    step_mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if (entrada !== 4'd0 || saida !== 4'd11 || ready_disp !== 1'b1) begin
        n_fail++; $display("FAIL step_hold: entrada=%0d saida=%0d ready_disp=%b expected 0 11 1", entrada, saida, ready_disp);
      end
    end
    avanca = 1'b1; tick(); avanca = 1'b0;
    n_checks++;
    if (entrada !== 4'd1 || ready_cod !== 1'b1) begin n_fail++; $display("FAIL step_adv1: entrada=%0d ready_cod=%b expected 1 1", entrada, ready_cod); end
    avanca = 1'b1; tick(); avanca = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (entrada !== 4'd1 || saida !== 4'd9) begin n_fail++; $display("FAIL apply_avanca_ignored: entrada=%0d saida=%0d expected 1 9", entrada, saida); end
    for (int p = 0; p < 2; p++) begin
      avanca = 1'b1; tick(); avanca = 1'b0;
      for (int i = 0; i < 12; i++) tick();
    end
    n_checks++;
    if (entrada !== 4'd3 || saida !== 4'd15 || ready_disp !== 1'b1) begin
      n_fail++; $display("FAIL step_adv3: entrada=%0d saida=%0d ready_disp=%b expected 3 15 1", entrada, saida, ready_disp);
    end
    abortar = 1'b1; tick(); abortar = 1'b0; step_mode = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL step_abort: busy=%b expected 0", busy); end
  endtask

  task automatic test_abort_and_async_reset;
    int caps, guard;
    start = 1'b1; tick(); start = 1'b0;
    caps = 0; guard = 0;
    while (caps < 6 && guard < 200) begin
      tick(); guard++;
      if (cap_valid) caps++;
    end
    n_checks++;
    if (caps != 6) begin n_fail++; $display("FAIL abort_wait: captures=%0d expected 6", caps); end
    tick();
    abortar = 1'b1; tick(); abortar = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || ready_cod !== 1'b0 || ready_disp !== 1'b0 || done !== 1'b0 || saida !== 4'd2 || soma !== 8'd48) begin
      n_fail++; $display("FAIL abort_state: busy=%b rc=%b rd=%b done=%b saida=%0d soma=%0d expected 0 0 0 0 2 48",
                         busy, ready_cod, ready_disp, done, saida, soma);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (soma !== 8'd0 || reset_disp !== 1'b1) begin n_fail++; $display("FAIL restart_clear: soma=%0d reset_disp=%b expected 0 1", soma, reset_disp); end
    tick();
    n_checks++;
    if (entrada !== 4'd0 || ready_cod !== 1'b1) begin n_fail++; $display("FAIL restart_idx: entrada=%0d ready_cod=%b expected 0 1", entrada, ready_cod); end
    guard = 0;
    while (!(ready_cod && entrada == 4'd7) && guard < 200) begin tick(); guard++; end
    n_checks++;
    if (!(ready_cod && entrada == 4'd7)) begin n_fail++; $display("FAIL reach_idx7: entrada=%0d ready_cod=%b expected 7 1", entrada, ready_cod); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== 22'd0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", outs); end
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (outs !== 22'd0) begin n_fail++; $display("FAIL post_reset_idle: got %h expected 0", outs); end
  endtask

  task automatic test_done_rearm;
    int guard;
    start = 1'b1;
    guard = 0;
    while (!done && guard < 300) begin tick(); guard++; end
    n_checks++;
    if (done !== 1'b1 || soma !== 8'd120) begin n_fail++; $display("FAIL rearm_done: done=%b soma=%0d expected 1 120", done, soma); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || reset_disp !== 1'b0) begin
      n_fail++; $display("FAIL done_hold: done=%b busy=%b reset_disp=%b expected 1 0 0", done, busy, reset_disp);
    end
    start = 1'b0; tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_to_idle: done=%b busy=%b expected 0 0", done, busy); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (reset_disp !== 1'b1 || soma !== 8'd0) begin n_fail++; $display("FAIL rearm_clr: reset_disp=%b soma=%0d expected 1 0", reset_disp, soma); end
    guard = 0;
    while (!done && guard < 300) begin tick(); guard++; end
    n_checks++;
    if (done !== 1'b1 || soma !== 8'd120 || saida !== 4'd13) begin
      n_fail++; $display("FAIL rearm_sweep: done=%b soma=%0d saida=%0d expected 1 120 13", done, soma, saida);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step();
    test_abort_and_async_reset();
    test_done_rearm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
